multiport_register_file: RTL

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 128 ++++++++++++
 1 files changed

// File: rtl/multiport_register_file.sv
// Multiport register file with two write ports (ALU and load writeback),
// parameterised combinational read ports with write bypass, and a per-register
// busy scoreboard tracking outstanding loads.

// One read lane: bypasses in-flight writes and scoreboard clears onto the read.
module multiport_register_file_rd_port #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                                 rst,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic [(1<<ADDR_W)-1:0]               busy,
    input  logic                                 wa_en,
    input  logic [ADDR_W-1:0]                    wa_addr,
    input  logic [DATA_W-1:0]                    wa_data,
    input  logic                                 wb_en,
    input  logic [ADDR_W-1:0]                    wb_addr,
    input  logic [DATA_W-1:0]                    wb_data,
    output logic [DATA_W-1:0]                    data,
    output logic                                 busy_out
);
    logic hit_a, hit_b;

    // Bypass only for nonzero addresses; wb has priority when both ports hit.
    always_comb begin
        hit_a    = wa_en && (wa_addr == addr) && (addr != '0);
        hit_b    = wb_en && (wb_addr == addr) && (addr != '0);
        data     = regs[addr];
        busy_out = busy[addr];
        if (rst || addr == '0) begin
            data     = '0;
            busy_out = 1'b0;
        end else if (hit_b) begin
            data     = wb_data;
            busy_out = 1'b0;
        end else if (hit_a) begin
            data     = wa_data;
        end
    end
endmodule

module multiport_register_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    output logic [ADDR_W:0]          busy_count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_nxt;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++)
            c = c + {{ADDR_W{1'b0}}, v[i]};
        return c;
    endfunction

    // Register array update; wb is applied last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            if (wa_en && wa_addr != '0) regs[wa_addr] <= wa_data;
            if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
        end
    end

    // Next scoreboard state: load writeback clears, load issue sets (set wins).
    always_comb begin
        busy_nxt = busy;
        if (wb_en && wb_addr != '0)     busy_nxt[wb_addr]   = 1'b0;
        if (mark_en && mark_addr != '0) busy_nxt[mark_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard and its population count registered together so they never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd
            multiport_register_file_rd_port #(
                .DATA_W(DATA_W),
                .ADDR_W(ADDR_W)
            ) u_rd (
                .rst      (rst),
                .addr     (read_addr[g*ADDR_W +: ADDR_W]),
                .regs     (regs),
                .busy     (busy),
                .wa_en    (wa_en),
                .wa_addr  (wa_addr),
                .wa_data  (wa_data),
                .wb_en    (wb_en),
                .wb_addr  (wb_addr),
                .wb_data  (wb_data),
                .data     (read_data[g*DATA_W +: DATA_W]),
                .busy_out (read_busy[g])
            );
        end
    endgenerate
endmodule
